// File: rtl/tdc_result_serializer.sv
// Readout stage for TDC measurement words: a shadow register catches each finished word, and the
// word is sent MSB-first on sframe/sclk/sdata with the overrun flag in front, on host request.
module tdc_result_serializer #(
  parameter int DATA_BITS = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_capture,
  input  logic [DATA_BITS-1:0] i_data_in,
  input  logic                 i_rd_start,
  output logic                 o_data_valid,
  output logic                 o_overrun,
  output logic                 o_busy,
  output logic                 o_sframe,
  output logic                 o_sclk,
  output logic                 o_sdata,
  output logic                 o_dbg_state
);

  localparam int FRAME_BITS = DATA_BITS + 1;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_BITS-1:0]  r_shadow;
  logic [FRAME_BITS-1:0] r_shift;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_data_valid;
  logic                  r_overrun;
  logic                  r_sframe;
  logic                  r_sclk;
  logic                  r_sdata;
  logic                  w_frame_start;
  logic                  w_phase_end;
  logic                  w_fall;
  logic                  w_last_bit;

  always_comb begin
    w_frame_start = (r_state == S_IDLE) && i_rd_start && r_data_valid;
    w_phase_end   = (r_state == S_SHIFT) && (r_div_cnt == DIV_LAST);
    w_fall        = w_phase_end && r_sclk;
    w_last_bit    = (r_bit_cnt == BIT_LAST);
    w_next_state  = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_fall && w_last_bit) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Shadow side: a frame start consumes the word, so a capture on that edge never counts as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (i_capture) r_shadow <= i_data_in;
      if (w_frame_start) begin
        r_data_valid <= i_capture;
        r_overrun    <= 1'b0;
      end else if (i_capture) begin
        r_data_valid <= 1'b1;
        if (r_data_valid) r_overrun <= 1'b1;
      end
    end
  end

  // Serializer side: each bit is CLK_DIV cycles low then CLK_DIV cycles high; data moves on the fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sframe  <= 1'b0;
      r_sclk    <= 1'b0;
      r_sdata   <= 1'b0;
    end else if (w_frame_start) begin
      r_shift   <= {r_overrun, r_shadow};
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sframe  <= 1'b1;
      r_sclk    <= 1'b0;
      r_sdata   <= r_overrun;
    end else if (r_state == S_SHIFT) begin
      if (w_phase_end) begin
        r_div_cnt <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_sclk    <= 1'b0;
          if (w_last_bit) begin
            r_sframe <= 1'b0;
            r_sdata  <= 1'b0;
          end else begin
            r_shift <= {r_shift[FRAME_BITS-2:0], r_shift[FRAME_BITS-1]};
            r_sdata <= r_shift[FRAME_BITS-2];
          end
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  assign o_data_valid = r_data_valid;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_sframe;
  assign o_sframe     = r_sframe;
  assign o_sclk       = r_sclk;
  assign o_sdata      = r_sdata;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_tdc_result_serializer.sv
// Bench for tdc_result_serializer: instance A (16 bits, CLK_DIV=2) and instance B (8 bits, CLK_DIV=1).
// Serial receivers rebuild each frame on sclk rises and compare it against the expected-frame queues.
module tb_tdc_result_serializer;

  localparam int LEN_A = 17 * 2 * 2;
  localparam int LEN_B = 9 * 2 * 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_cap = 1'b0, a_rd = 1'b0;
  logic [15:0] a_data = '0;
  logic        a_dv, a_ov, a_busy, a_sf, a_sclk, a_sd, a_st;
  logic        b_cap = 1'b0, b_rd = 1'b0;
  logic [7:0]  b_data = '0;
  logic        b_dv, b_ov, b_busy, b_sf, b_sclk, b_sd, b_st;

  int n_chk = 0;
  int n_err = 0;
  logic [16:0] exp_a[$];
  logic [8:0]  exp_b[$];

  always #5 clk = ~clk;

  tdc_result_serializer #(.DATA_BITS(16), .CLK_DIV(2)) u_a (
    .clk(clk), .rst(rst), .i_capture(a_cap), .i_data_in(a_data), .i_rd_start(a_rd),
    .o_data_valid(a_dv), .o_overrun(a_ov), .o_busy(a_busy), .o_sframe(a_sf),
    .o_sclk(a_sclk), .o_sdata(a_sd), .o_dbg_state(a_st));

  tdc_result_serializer #(.DATA_BITS(8), .CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .i_capture(b_cap), .i_data_in(b_data), .i_rd_start(b_rd),
    .o_data_valid(b_dv), .o_overrun(b_ov), .o_busy(b_busy), .o_sframe(b_sf),
    .o_sclk(b_sclk), .o_sdata(b_sd), .o_dbg_state(b_st));

  // Receiver A
  logic        pf_a = 1'b0, pc_a = 1'b0;
  logic [16:0] rx_a = '0;
  int          nb_a = 0, len_a = 0;
  logic [16:0] e_a;
  always @(negedge clk) begin
    if (rst) begin
      pf_a = 1'b0; pc_a = 1'b0; rx_a = '0; nb_a = 0; len_a = 0;
    end else begin
      n_chk++;
      if (a_busy !== a_sf) begin
        n_err++; $display("FAIL a_busy_eq_sframe: busy=%b sframe=%b", a_busy, a_sf);
      end
      if (a_sf) begin
        len_a++;
        if (a_sclk && !pc_a) begin rx_a = {rx_a[15:0], a_sd}; nb_a++; end
      end else begin
        n_chk++;
        if (a_sclk !== 1'b0 || a_sd !== 1'b0) begin
          n_err++; $display("FAIL a_idle_lines: sclk=%b sdata=%b want 0 0", a_sclk, a_sd);
        end
        if (pf_a) begin
          n_chk++;
          if (exp_a.size() == 0) begin
            n_err++; $display("FAIL a_unexpected_frame: got %05h with none expected", rx_a);
          end else begin
            e_a = exp_a.pop_front();
            if (rx_a !== e_a || nb_a != 17 || len_a != LEN_A) begin
              n_err++;
              $display("FAIL a_frame: got %05h bits=%0d len=%0d want %05h bits=17 len=%0d",
                       rx_a, nb_a, len_a, e_a, LEN_A);
            end
          end
          rx_a = '0; nb_a = 0; len_a = 0;
        end
      end
      pf_a = a_sf; pc_a = a_sclk;
    end
  end

  // Receiver B
  logic       pf_b = 1'b0, pc_b = 1'b0;
  logic [8:0] rx_b = '0;
  int         nb_b = 0, len_b = 0;
  logic [8:0] e_b;
  always @(negedge clk) begin
    if (rst) begin
      pf_b = 1'b0; pc_b = 1'b0; rx_b = '0; nb_b = 0; len_b = 0;
    end else begin
      if (b_sf) begin
        len_b++;
        if (b_sclk && !pc_b) begin rx_b = {rx_b[7:0], b_sd}; nb_b++; end
      end else if (pf_b) begin
        n_chk++;
        if (exp_b.size() == 0) begin
          n_err++; $display("FAIL b_unexpected_frame: got %03h with none expected", rx_b);
        end else begin
          e_b = exp_b.pop_front();
          if (rx_b !== e_b || nb_b != 9 || len_b != LEN_B) begin
            n_err++;
            $display("FAIL b_frame: got %03h bits=%0d len=%0d want %03h bits=9 len=%0d",
                     rx_b, nb_b, len_b, e_b, LEN_B);
          end
        end
        rx_b = '0; nb_b = 0; len_b = 0;
      end
      pf_b = b_sf; pc_b = b_sclk;
    end
  end

  task automatic cap_a(input logic [15:0] w);
    @(negedge clk); a_cap = 1'b1; a_data = w;
    @(negedge clk); a_cap = 1'b0;
  endtask

  task automatic rd_a();
    @(negedge clk); a_rd = 1'b1;
    @(negedge clk); a_rd = 1'b0;
  endtask

  task automatic cap_b(input logic [7:0] w);
    @(negedge clk); b_cap = 1'b1; b_data = w;
    @(negedge clk); b_cap = 1'b0;
  endtask

  task automatic rd_b();
    @(negedge clk); b_rd = 1'b1;
    @(negedge clk); b_rd = 1'b0;
  endtask

  task automatic wait_frames(input bit sel_b);
    int t = 0;
    while (((sel_b ? exp_b.size() : exp_a.size()) != 0) && t < 3000) begin
      @(posedge clk); t++;
    end
    n_chk++;
    if ((sel_b ? exp_b.size() : exp_a.size()) != 0) begin
      n_err++; $display("FAIL wait_frames: %0d frames still pending, want 0",
                        sel_b ? exp_b.size() : exp_a.size());
      exp_a.delete(); exp_b.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_dv, a_ov, a_busy, a_sf, a_sclk, a_sd, a_st} !== 7'b0) begin
      n_err++; $display("FAIL reset_a_outputs: got %b want 0000000",
                        {a_dv, a_ov, a_busy, a_sf, a_sclk, a_sd, a_st});
    end
    n_chk++;
    if ({b_dv, b_ov, b_busy, b_sf, b_sclk, b_sd, b_st} !== 7'b0) begin
      n_err++; $display("FAIL reset_b_outputs: got %b want 0000000",
                        {b_dv, b_ov, b_busy, b_sf, b_sclk, b_sd, b_st});
    end
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_single_frame();
    cap_a(16'hA5C3);
    n_chk++;
    if (a_dv !== 1'b1 || a_ov !== 1'b0) begin
      n_err++; $display("FAIL single_capture: dv=%b ov=%b want 1 0", a_dv, a_ov);
    end
    exp_a.push_back({1'b0, 16'hA5C3});
    rd_a();
    n_chk++;
    if ({a_sf, a_busy, a_dv, a_sclk, a_sd} !== 5'b11000) begin
      n_err++; $display("FAIL single_start: sf,busy,dv,sclk,sd=%b want 11000",
                        {a_sf, a_busy, a_dv, a_sclk, a_sd});
    end
    wait_frames(1'b0);
  endtask

  task automatic test_overrun();
    cap_a(16'h0001);
    cap_a(16'h0002);
    n_chk++;
    if (a_dv !== 1'b1 || a_ov !== 1'b1) begin
      n_err++; $display("FAIL overrun_set: dv=%b ov=%b want 1 1", a_dv, a_ov);
    end
    exp_a.push_back({1'b1, 16'h0002});
    rd_a();
    n_chk++;
    if (a_ov !== 1'b0 || a_dv !== 1'b0 || a_sd !== 1'b1) begin
      n_err++; $display("FAIL overrun_start: ov=%b dv=%b sd=%b want 0 0 1", a_ov, a_dv, a_sd);
    end
    wait_frames(1'b0);
    cap_a(16'h5A3C);
    exp_a.push_back({1'b0, 16'h5A3C});
    rd_a();
    wait_frames(1'b0);
  endtask

  task automatic test_no_data_and_midframe();
    int act = 0;
    rd_a();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_sf || a_sclk) act++;
    end
    n_chk++;
    if (act != 0) begin
      n_err++; $display("FAIL no_data_rd: active cycles=%0d want 0", act);
    end
    cap_a(16'hBEEF);
    exp_a.push_back({1'b0, 16'hBEEF});
    rd_a();
    repeat (8) @(negedge clk);
    cap_a(16'h1234);
    n_chk++;
    if (a_sf !== 1'b1 || a_dv !== 1'b1 || a_ov !== 1'b0) begin
      n_err++; $display("FAIL midframe_capture: sf=%b dv=%b ov=%b want 1 1 0", a_sf, a_dv, a_ov);
    end
    wait_frames(1'b0);
    exp_a.push_back({1'b0, 16'h1234});
    rd_a();
    wait_frames(1'b0);
  endtask

  task automatic test_simultaneous();
    cap_a(16'h00FF);
    exp_a.push_back({1'b0, 16'h00FF});
    @(negedge clk); a_cap = 1'b1; a_data = 16'hFF00; a_rd = 1'b1;
    @(negedge clk); a_cap = 1'b0; a_rd = 1'b0;
    n_chk++;
    if (a_sf !== 1'b1 || a_dv !== 1'b1 || a_ov !== 1'b0) begin
      n_err++; $display("FAIL simul_valid: sf=%b dv=%b ov=%b want 1 1 0", a_sf, a_dv, a_ov);
    end
    wait_frames(1'b0);
    exp_a.push_back({1'b0, 16'hFF00});
    rd_a();
    wait_frames(1'b0);
    @(negedge clk); a_cap = 1'b1; a_data = 16'h7777; a_rd = 1'b1;
    @(negedge clk); a_cap = 1'b0; a_rd = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (a_sf !== 1'b0 || a_dv !== 1'b1) begin
      n_err++; $display("FAIL simul_empty: sf=%b dv=%b want 0 1", a_sf, a_dv);
    end
    exp_a.push_back({1'b0, 16'h7777});
    rd_a();
    wait_frames(1'b0);
  endtask

  task automatic test_back_to_back();
    int t = 0;
    cap_a(16'h0F0F);
    exp_a.push_back({1'b0, 16'h0F0F});
    a_rd = 1'b1;
    cap_a(16'hF0F0);
    exp_a.push_back({1'b0, 16'hF0F0});
    while (a_sf !== 1'b0 && t < 200) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    n_chk++;
    if (a_sf !== 1'b1) begin
      n_err++; $display("FAIL back_to_back_gap: sframe=%b one cycle after end, want 1", a_sf);
    end
    a_rd = 1'b0;
    wait_frames(1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int act = 0;
    cap_a(16'hFFFF);
    rd_a();
    cap_a(16'h1111);
    cap_a(16'h2222);
    repeat (26) @(posedge clk);
    #2;
    n_chk++;
    if ({a_sf, a_sclk, a_sd, a_dv, a_ov} !== 5'b11111) begin
      n_err++; $display("FAIL pre_reset_bit7: sf,sclk,sd,dv,ov=%b want 11111",
                        {a_sf, a_sclk, a_sd, a_dv, a_ov});
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({a_sf, a_sclk, a_sd, a_dv, a_ov, a_busy} !== 6'b0) begin
      n_err++; $display("FAIL async_reset: sf,sclk,sd,dv,ov,busy=%b want 000000",
                        {a_sf, a_sclk, a_sd, a_dv, a_ov, a_busy});
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    rd_a();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_sf || a_sclk) act++;
    end
    n_chk++;
    if (act != 0 || a_dv !== 1'b0) begin
      n_err++; $display("FAIL post_reset_rd: active=%0d dv=%b want 0 0", act, a_dv);
    end
  endtask

  task automatic test_div1();
    cap_b(8'h80);
    exp_b.push_back({1'b0, 8'h80});
    rd_b();
    n_chk++;
    if (b_sf !== 1'b1 || b_sd !== 1'b0 || b_dv !== 1'b0) begin
      n_err++; $display("FAIL div1_start: sf=%b sd=%b dv=%b want 1 0 0", b_sf, b_sd, b_dv);
    end
    @(negedge clk);
    n_chk++;
    if (b_sclk !== 1'b1) begin
      n_err++; $display("FAIL div1_toggle: sclk=%b want 1", b_sclk);
    end
    wait_frames(1'b1);
    cap_b(8'h3C);
    cap_b(8'hA7);
    exp_b.push_back({1'b1, 8'hA7});
    rd_b();
    wait_frames(1'b1);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_no_data_and_midframe();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_frame();
    test_div1();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
